// File: rtl/audio_pkg.sv
// Shared definitions for the stereo delta-sigma DAC: default geometry,
// the stereo sample pair type and the signed-to-offset-binary conversion.
package audio_pkg;

  localparam int unsigned AUDIO_WIDTH = 16;
  localparam int unsigned AUDIO_OSR   = 256;

  typedef struct packed {
    logic signed [AUDIO_WIDTH-1:0] l;
    logic signed [AUDIO_WIDTH-1:0] r;
  } audio_pair_t;

  // Flipping the sign bit maps -2^(W-1)..2^(W-1)-1 onto 0..2^W-1.
  function automatic logic [AUDIO_WIDTH-1:0] audio_to_offset(input logic [AUDIO_WIDTH-1:0] s);
    return {~s[AUDIO_WIDTH-1], s[AUDIO_WIDTH-2:0]};
  endfunction

endpackage

// File: rtl/audio_dsm_channel.sv
// One channel of the first-order delta-sigma modulator: the carry out of
// the phase accumulator is the registered 1-bit output.
module audio_dsm_channel #(
  parameter int unsigned WIDTH = audio_pkg::AUDIO_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] u,
  output logic             out
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH:0]   acc_d;

  assign acc_d = {1'b0, acc_q} + {1'b0, u};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      out   <= 1'b0;
    end else begin
      acc_q <= acc_d[WIDTH-1:0];
      out   <= acc_d[WIDTH];
    end
  end

endmodule

// File: rtl/audio_dsm_dac.sv
// Stereo PCM to 1-bit delta-sigma DAC with a one-pair input buffer.
// Optional AUDIO_DSM_UNDERRUN_CNT_EN adds a saturating underrun_count output.
module audio_dsm_dac
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH = AUDIO_WIDTH,
  parameter int unsigned OSR   = AUDIO_OSR
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_l,
  input  logic signed [WIDTH-1:0] in_r,
  output logic                    audio_l,
  output logic                    audio_r,
  output logic                    sample_tick,
`ifdef AUDIO_DSM_UNDERRUN_CNT_EN
  output logic                    underrun,
  output logic [15:0]             underrun_count
`else
  output logic                    underrun
`endif
);

  localparam int unsigned CW = (OSR > 1) ? $clog2(OSR) : 1;

  typedef struct packed {
    logic signed [WIDTH-1:0] l;
    logic signed [WIDTH-1:0] r;
  } pair_t;

  logic [CW-1:0] cnt_q, cnt_d;
  pair_t         buf_q, buf_d;
  pair_t         cur_q, cur_d;
  logic          buf_full_q, buf_full_d;
  logic          tick_q, underrun_q;
  logic          last, xfer;
  logic [WIDTH-1:0] u_l, u_r;

  assign last     = (cnt_q == CW'(OSR - 1));
  assign in_ready = ~buf_full_q;
  assign xfer     = in_valid & ~buf_full_q;

  // The tick reads buf_full_q from before the edge, so a coincident
  // transfer into an empty buffer both underruns and lands in the buffer.
  always_comb begin
    cnt_d      = last ? '0 : cnt_q + CW'(1);
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    cur_d      = cur_q;
    if (last && buf_full_q) begin
      cur_d      = buf_q;
      buf_full_d = 1'b0;
    end
    if (xfer) begin
      buf_d      = {in_l, in_r};
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      buf_q      <= '0;
      cur_q      <= '0;
      buf_full_q <= 1'b0;
      tick_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      cur_q      <= cur_d;
      buf_full_q <= buf_full_d;
      tick_q     <= last;
      underrun_q <= last & ~buf_full_q;
    end
  end

  assign sample_tick = tick_q;
  assign underrun    = underrun_q;

  if (WIDTH == AUDIO_WIDTH) begin : g_pkg_conv
    assign u_l = audio_to_offset(cur_q.l);
    assign u_r = audio_to_offset(cur_q.r);
  end else begin : g_inline_conv
    assign u_l = {~cur_q.l[WIDTH-1], cur_q.l[WIDTH-2:0]};
    assign u_r = {~cur_q.r[WIDTH-1], cur_q.r[WIDTH-2:0]};
  end

  audio_dsm_channel #(.WIDTH(WIDTH)) u_chan_l (
    .clk     (clk),
    .reset_n (reset_n),
    .u       (u_l),
    .out     (audio_l)
  );

  audio_dsm_channel #(.WIDTH(WIDTH)) u_chan_r (
    .clk     (clk),
    .reset_n (reset_n),
    .u       (u_r),
    .out     (audio_r)
  );

`ifdef AUDIO_DSM_UNDERRUN_CNT_EN
  logic [15:0] urc_q, urc_d;

  always_comb begin
    urc_d = urc_q;
    if (underrun_q && (urc_q != 16'hFFFF)) urc_d = urc_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) urc_q <= '0;
    else          urc_q <= urc_d;
  end

  assign underrun_count = urc_q;
`endif

endmodule

// File: tb/tb_audio_dsm_dac.sv
// Directed bench for audio_dsm_dac: reset, midscale, backpressure,
// coincident tick, a table of density vectors and mid-run reset.
module tb_audio_dsm_dac;
  import audio_pkg::*;

  localparam int unsigned W   = 16;
  localparam int unsigned OSR = 256;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic signed [W-1:0] in_l = '0;
  logic signed [W-1:0] in_r = '0;
  logic in_ready, audio_l, audio_r, sample_tick, underrun;
`ifdef AUDIO_DSM_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
  logic clk2 = 1'b0;
  logic rst2_n = 1'b0;
  logic in_ready2, audio_l2, audio_r2, tick2, underrun2;
  logic [15:0] urc2;
  logic done2 = 1'b0;
  always #1 clk2 = ~clk2;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  audio_dsm_dac #(.WIDTH(W), .OSR(OSR)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_l           (in_l),
    .in_r           (in_r),
    .audio_l        (audio_l),
    .audio_r        (audio_r),
    .sample_tick    (sample_tick),
`ifdef AUDIO_DSM_UNDERRUN_CNT_EN
    .underrun       (underrun),
    .underrun_count (underrun_count)
`else
    .underrun       (underrun)
`endif
  );

`ifdef AUDIO_DSM_UNDERRUN_CNT_EN
  audio_dsm_dac #(.WIDTH(W), .OSR(2)) dut2 (
    .clk            (clk2),
    .reset_n        (rst2_n),
    .in_valid       (1'b0),
    .in_ready       (in_ready2),
    .in_l           (16'sd0),
    .in_r           (16'sd0),
    .audio_l        (audio_l2),
    .audio_r        (audio_r2),
    .sample_tick    (tick2),
    .underrun       (underrun2),
    .underrun_count (urc2)
  );
`endif

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          lmin, lmax, rmin, rmax;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Polls negedges until sample_tick is seen; n = negedges consumed.
  task automatic wait_tick(output int n);
    logic found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < int'(OSR) + 4 && !found; i++) begin
      @(negedge clk);
      n++;
      if (sample_tick) found = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL wait_tick: got no tick, expected one within %0d clocks", OSR + 4);
    end
  endtask

  task automatic measure(output int ol, output int orr, output int tk, output int ur);
    ol = 0; orr = 0; tk = 0; ur = 0;
    repeat (OSR) begin
      @(negedge clk);
      ol  += int'(audio_l);
      orr += int'(audio_r);
      tk  += int'(sample_tick);
      ur  += int'(underrun);
    end
  endtask

  initial begin
    int n, ol, orr, tk, ur;
    logic bp_high, found;

    // u = s ^ 0x8000; ones per 256 clocks = u/256 (+-1)
    vecs[0] = '{16'h7FFF, 16'h8000, 255, 256,   0,   0};
    vecs[1] = '{16'h8000, 16'h7FFF,   0,   0, 255, 256};
    vecs[2] = '{16'h4000, 16'hC000, 191, 193,  63,  65};
    vecs[3] = '{16'h0000, 16'h2000, 127, 129, 159, 161};
    vecs[4] = '{16'hE000, 16'h0000,  95,  97, 127, 129};

    in_valid = 1'b1;
    in_l = 16'sh7FFF;
    in_r = 16'sh7FFF;
    repeat (4) @(negedge clk);
    chk("rst_audio_l", int'(audio_l), 0, 0);
    chk("rst_audio_r", int'(audio_r), 0, 0);
    chk("rst_in_ready", int'(in_ready), 1, 1);
    chk("rst_sample_tick", int'(sample_tick), 0, 0);
    chk("rst_underrun", int'(underrun), 0, 0);
`ifdef AUDIO_DSM_UNDERRUN_CNT_EN
    chk("rst_underrun_count", int'(underrun_count), 0, 0);
`endif
    reset_n  = 1'b1;
    in_valid = 1'b0;
    wait_tick(n);
    chk("first_tick_latency", n, 256, 256);
    chk("first_tick_underrun", int'(underrun), 1, 1);

    measure(ol, orr, tk, ur);
    chk("mid_ones_l", ol, 127, 129);
    chk("mid_ones_r", orr, 127, 129);
    chk("mid_ticks", tk, 1, 1);
    chk("mid_underruns", ur, 1, 1);

    // Backpressure: A accepted just after a tick, B waits for the next tick.
    in_l = 16'sh4000;
    in_r = 16'sh4000;
    in_valid = 1'b1;
    chk("bp_ready_first", int'(in_ready), 1, 1);
    @(negedge clk);
    in_l = -16'sh4000;
    in_r = -16'sh4000;
    bp_high = 1'b0;
    found = 1'b0;
    for (int i = 0; i < int'(OSR) + 4 && !found; i++) begin
      if (sample_tick) found = 1'b1;
      else begin
        if (in_ready) bp_high = 1'b1;
        @(negedge clk);
      end
    end
    chk("bp_tick_seen", int'(found), 1, 1);
    chk("bp_ready_low_until_tick", int'(bp_high), 0, 0);
    chk("bp_ready_at_tick", int'(in_ready), 1, 1);
    measure(ol, orr, tk, ur);
    chk("bp_A_ones_l", ol, 191, 193);
    chk("bp_A_ones_r", orr, 191, 193);
    chk("bp_A_underruns", ur, 0, 0);
    measure(ol, orr, tk, ur);
    chk("bp_B_ones_l", ol, 63, 65);
    chk("bp_B_ones_r", orr, 63, 65);

    // Coincident: transfer in the cnt==OSR-1 cycle with an empty buffer.
    in_valid = 1'b0;
    wait_tick(n);
    repeat (OSR - 1) @(negedge clk);
    in_l = 16'sh4000;
    in_r = -16'sh2000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("coin_tick", int'(sample_tick), 1, 1);
    chk("coin_underrun", int'(underrun), 1, 1);
    chk("coin_buffered", int'(in_ready), 0, 0);
    wait_tick(n);
    chk("coin_use_no_underrun", int'(underrun), 0, 0);
    measure(ol, orr, tk, ur);
    chk("coin_ones_l", ol, 191, 193);
    chk("coin_ones_r", orr, 95, 97);

    for (int i = 0; i < 5; i++) begin
      in_l = vecs[i].l;
      in_r = vecs[i].r;
      in_valid = 1'b1;
      wait_tick(n);
      wait_tick(n);
      measure(ol, orr, tk, ur);
      chk($sformatf("vec%0d_ones_l", i), ol, vecs[i].lmin, vecs[i].lmax);
      chk($sformatf("vec%0d_ones_r", i), orr, vecs[i].rmin, vecs[i].rmax);
      chk($sformatf("vec%0d_ticks", i), tk, 1, 1);
      chk($sformatf("vec%0d_underruns", i), ur, 0, 0);
    end

    // Asynchronous reset with a pair still buffered.
    @(negedge clk);
    reset_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mrst_audio_l", int'(audio_l), 0, 0);
    chk("mrst_audio_r", int'(audio_r), 0, 0);
    chk("mrst_in_ready", int'(in_ready), 1, 1);
    chk("mrst_sample_tick", int'(sample_tick), 0, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_tick(n);
    chk("mrst_tick_latency", n, 256, 256);
    chk("mrst_underrun", int'(underrun), 1, 1);
    measure(ol, orr, tk, ur);
    chk("mrst_ones_l", ol, 127, 129);
    chk("mrst_ones_r", orr, 127, 129);
`ifdef AUDIO_DSM_UNDERRUN_CNT_EN
    @(negedge clk);
    chk("mrst_underrun_count", int'(underrun_count), 2, 2);
    for (int i = 0; i < 300000 && !done2; i++) @(negedge clk2);
    chk("cnt_done", int'(done2), 1, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

`ifdef AUDIO_DSM_UNDERRUN_CNT_EN
  initial begin
    logic reached;
    repeat (3) @(negedge clk2);
    chk("cnt_reset", int'(urc2), 0, 0);
    rst2_n = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 140000 && !reached; i++) begin
      @(negedge clk2);
      if (urc2 == 16'hFFFF) reached = 1'b1;
    end
    chk("cnt_saturated", int'(reached), 1, 1);
    repeat (10) @(negedge clk2);
    chk("cnt_holds", int'(urc2), 65535, 65535);
    rst2_n = 1'b0;
    #1;
    chk("cnt_cleared", int'(urc2), 0, 0);
    done2 = 1'b1;
  end
`endif

endmodule

// File: doc/audio_dsm_dac.md
# audio_dsm_dac

Stereo PCM-to-1-bit first-order delta-sigma DAC. It accepts signed stereo samples over a valid/ready handshake and buffers one sample pair. At a fixed oversampling rate it drives the 1-bit audio_l/audio_r pins, which feed the board's RC filters. It runs entirely in the audio clock domain, downstream of the sample-producing logic and directly in front of the audio GPIO pins.

## Interface
- WIDTH, 16: sample width, signed two's complement.
- OSR, 256: clocks per sample period; must be ≥2.
- clk  in  1  audio clock; all logic is synchronous to it.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  a sample pair is presented.
- in_ready  out  1  the block can accept a sample pair; equals ~buf_full.
- in_l, in_r  in  WIDTH  signed left/right samples; transferred when in_valid & in_ready.
- audio_l, audio_r  out  1  registered 1-bit modulator outputs.
- sample_tick  out  1  one-cycle pulse at the end of each sample period.
- underrun  out  1  one-cycle pulse on a tick at which the buffer was empty.

## Operation
- Sample buffer: one register pair plus a buf_full flag.
  - A transfer sets buf_full.
  - A tick with buf_full set copies the buffer into cur_l/cur_r and clears buf_full.
- Period counter: cnt runs 0..OSR-1 and wraps to 0. sample_tick is asserted (registered) for the cycle after cnt==OSR-1.
- Tick with empty buffer:
  - cur_l/cur_r hold their last values.
  - underrun pulses.
- Simultaneous transfer and tick: the tick sees buf_full as registered before the edge.
  - If the buffer was empty, underrun fires and the new pair lands in the buffer; it is used at the next tick.
  - If the buffer was full, in_ready is 0, so no transfer can occur.
- Offset conversion: u = {~s[WIDTH-1], s[WIDTH-2:0]}, an unsigned WIDTH-bit value.
- Modulator, per channel, every clock:
  - acc_next = {1'b0, acc[WIDTH-1:0]} + u, computed in WIDTH+1 bits.
  - audio_x <= acc_next[WIDTH].
  - The long-run density of ones is exactly u/2^WIDTH.
- Reset values:
  - audio_l/audio_r, sample_tick, underrun = 0.
  - in_ready = 1, but transfers are ignored while reset_n is low.
  - acc = 0, cnt = 0, buf_full = 0.
  - cur_l/cur_r = 0, which gives 50% density after reset.
- Reset mid-operation: every register above returns to its reset value immediately. Any buffered sample is discarded.

## Timing
- The handshake is a standard ready/valid transfer on the rising edge; in_ready does not depend on in_valid.
- Latency:
  - A pair accepted while the buffer is empty becomes current at the next tick edge.
  - It first affects audio_x one clock later.
  - Worst-case latency is OSR+1 clocks.
- Backpressure: with buf_full set, in_ready stays low until the clock after the next tick, which is at most OSR cycles.
- After reset_n deasserts, the first tick occurs OSR clocks later, and sample_tick pulses every OSR clocks thereafter.

## Configuration
- AUDIO_DSM_UNDERRUN_CNT_EN
  - Defined: adds output underrun_count [15:0]. It increments on each underrun pulse, saturates at 16'hFFFF, and resets to 0.
  - Undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Shared package audio_pkg:
  - AUDIO_WIDTH default (16) and AUDIO_OSR default (256).
  - typedef of the stereo sample pair.
  - Function for the signed-to-offset conversion.
- Sub-module audio_dsm_channel:
  - Holds the accumulator and output register for one channel.
  - Ports: clk, reset_n, u[WIDTH-1:0], out.
  - Instantiated twice; the buffer, counter and handshake stay in the top.

## Test plan
- Reset: hold reset_n low while driving in_valid=1.
  - Expect audio_l/audio_r=0, in_ready=1, no transfer.
  - After release, expect the first sample_tick exactly 256 clocks later.
- Midscale: with no input, count ones on audio_l over 256 clocks after the first tick. Expect 128±1, and one underrun per tick.
- Extremes: feed 16'h7FFF/16'h8000 (L/R) continuously.
  - Per 256-clock window, expect ≥255 ones on audio_l and 0 ones on audio_r.
  - Expect no underrun.
- Backpressure: present two pairs back-to-back.
  - The first is accepted immediately.
  - in_ready is then low until the clock after the next tick, and the second pair is accepted then.
  - Check cur values via output density: 16'h4000 gives 192±1 ones per period.
- Coincident tick: with the buffer empty, transfer a pair in the same cycle as cnt==OSR-1.
  - Expect underrun to pulse.
  - Expect the pair to become current at the following tick.
- Counter (AUDIO_DSM_UNDERRUN_CNT_EN): starve 70000 ticks (shorten with OSR=2). Expect underrun_count to saturate at 16'hFFFF; reset clears it to 0.
